// File: rtl/flit_tracker.sv
// Packet-framing tracker: a single register slice that classifies flits, enforces
// HEAD/PAYLOAD/TAIL ordering and length limits, and reports sequence/length errors.
module flit_tracker #(
  parameter int DATA_WIDTH  = 32,
  parameter int PhitPerFlit = 2,
  parameter int TYPE_WIDTH  = 2,
  parameter int HEAD_ID     = 1,
  parameter int PAYLOAD_ID  = 2,
  parameter int TAIL_ID     = 3,
  parameter int MAX_FLITS   = 16,
  localparam int FW = DATA_WIDTH * PhitPerFlit,
  localparam int CW = $clog2(MAX_FLITS + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [FW-1:0]         in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [FW-1:0]         out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [TYPE_WIDTH-1:0] out_type,
  output logic [CW-1:0]         pkt_len,
  output logic                  err_seq,
  output logic                  err_len,
  output logic [7:0]            err_count
);

  typedef enum logic {IDLE, BODY} state_e;
  typedef enum logic [1:0] {K_DEFAULT, K_HEAD, K_PAYLOAD, K_TAIL} kind_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  valid_q, valid_d;
  logic [FW-1:0]         data_q, data_d;
  logic [TYPE_WIDTH-1:0] type_q, type_d;
  logic [CW-1:0]         len_q, len_d;
  logic                  err_seq_q, err_seq_d;
  logic                  err_len_q, err_len_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  logic [TYPE_WIDTH-1:0] in_field;
  kind_e                 kind;
  logic                  accept;
  logic                  fwd;
  logic [CW-1:0]         tail_len;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign in_field = in_data[FW-1 -: TYPE_WIDTH];

  always_comb begin
    kind = K_DEFAULT;
    if      (in_field == TYPE_WIDTH'(HEAD_ID))    kind = K_HEAD;
    else if (in_field == TYPE_WIDTH'(PAYLOAD_ID)) kind = K_PAYLOAD;
    else if (in_field == TYPE_WIDTH'(TAIL_ID))    kind = K_TAIL;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    fwd       = 1'b0;
    err_seq_d = 1'b0;
    err_len_d = 1'b0;
    tail_len  = '0;
    if (accept) begin
      unique case (state_q)
        IDLE: begin
          if (kind == K_HEAD) begin
            fwd     = 1'b1;
            cnt_d   = CW'(1);
            state_d = BODY;
          end else begin
            err_seq_d = 1'b1;
          end
        end
        BODY: begin
          unique case (kind)
            K_HEAD: begin
              err_seq_d = 1'b1;
              fwd       = 1'b1;
              cnt_d     = CW'(1);
            end
            K_PAYLOAD: begin
              if (cnt_q == CW'(MAX_FLITS - 1)) begin
                err_len_d = 1'b1;
                cnt_d     = '0;
                state_d   = IDLE;
              end else begin
                fwd   = 1'b1;
                cnt_d = cnt_q + CW'(1);
              end
            end
            K_TAIL: begin
              fwd      = 1'b1;
              tail_len = cnt_q + CW'(1);
              cnt_d    = '0;
              state_d  = IDLE;
            end
            default: err_seq_d = 1'b1;
          endcase
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A dropped flit never loads the slice; only a pop can clear out_valid.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    type_d  = type_q;
    len_d   = len_q;
    if (fwd) begin
      valid_d = 1'b1;
      data_d  = in_data;
      type_d  = TYPE_WIDTH'(kind);
      len_d   = tail_len;
    end else if (out_ready) begin
      valid_d = 1'b0;
      len_d   = '0;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if ((err_seq_d || err_len_d) && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      type_q    <= '0;
      len_q     <= '0;
      err_seq_q <= 1'b0;
      err_len_q <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      type_q    <= type_d;
      len_q     <= len_d;
      err_seq_q <= err_seq_d;
      err_len_q <= err_len_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_type  = type_q;
  assign pkt_len   = (valid_q && type_q == TYPE_WIDTH'(K_TAIL)) ? len_q : '0;
  assign err_seq   = err_seq_q;
  assign err_len   = err_len_q;
  assign err_count = err_cnt_q;

endmodule
